pc_fetch_unit: RTL and testbench

//   Fetch stage of the MIPS32 SOC core: holds the PC, fetches one instruction at a time

---
 rtl/pc_fetch_unit.sv | 119 +++++++++++
 tb/tb_pc_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch stage of the MIPS32 SOC core.
// Holds the PC, fetches one instruction at a time over an imem req/ack handshake,
// issues it downstream with its PC and jal link value, and forms the next PC from
// the redirect returned on accept. An illegal next PC raises the sticky invpc flag
// and halts the unit until reset.
//
// Ports:
//   clk_i              clock, rising edge
//   rst_ni             asynchronous active-low reset
//   imem_addr_o        fetch byte address (= pc)
//   imem_req_o         fetch request, held until imem_ack_i
//   imem_ack_i         imem_rdata_i valid this cycle
//   imem_rdata_i       instruction word
//   instr_o            issued instruction
//   instr_valid_o      instr_o / pc_out_o / link_addr_o valid
//   instr_ready_i      downstream accepts the issued instruction
//   pc_out_o           PC of the issued instruction
//   link_addr_o        pc_out_o + 4
//   redirect_valid_i   issued instruction changes flow (sampled on accept only)
//   redirect_kind_i    00 branch, 01 j/jal, 10 jr, 11 reserved
//   redirect_imm_i     [15:0] signed word offset, [25:0] jump index
//   redirect_reg_i     rs value for jr
//   invpc_o            sticky illegal-PC flag, core halted
module pc_fetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] pc_out_o,
  output logic [31:0] link_addr_o,
  input  logic        redirect_valid_i,
  input  logic [1:0]  redirect_kind_i,
  input  logic [25:0] redirect_imm_i,
  input  logic [31:0] redirect_reg_i,
  output logic        invpc_o
);

  // 33 bits so the limit itself is representable even for a full 4 GiB range.
  localparam logic [32:0] ImemBytes = 33'(IMEM_WORDS) << 2;

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] link_q;

  logic [31:0] pc4;
  logic [31:0] npc;
  logic        kind_bad;
  logic        npc_illegal;

  // Next-PC formation; only consumed on an accepted issue.
  always_comb begin
    pc4      = pc_q + 32'd4;
    npc      = pc4;
    kind_bad = 1'b0;
    if (redirect_valid_i) begin
      case (redirect_kind_i)
        2'b00:   npc = pc4 + {{14{redirect_imm_i[15]}}, redirect_imm_i[15:0], 2'b00};
        2'b01:   npc = {pc4[31:28], redirect_imm_i, 2'b00};
        2'b10:   npc = redirect_reg_i;
        default: kind_bad = 1'b1;
      endcase
    end
    // Sequential wrap past the top lands at or above ImemBytes and is caught here too.
    npc_illegal = kind_bad || (npc[1:0] != 2'b00) || ({1'b0, npc} >= ImemBytes);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      link_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (imem_ack_i) begin
            instr_q <= imem_rdata_i;
            link_q  <= pc_q + 32'd4;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (instr_ready_i) begin
            if (npc_illegal) begin
              // pc stays at the last legal value for post-mortem.
              state_q <= StHalt;
            end else begin
              pc_q    <= npc;
              state_q <= StFetch;
            end
          end
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_addr_o   = pc_q;
  assign imem_req_o    = (state_q == StFetch);
  assign instr_o       = instr_q;
  assign instr_valid_o = (state_q == StIssue);
  assign pc_out_o      = pc_q;
  assign link_addr_o   = link_q;
  assign invpc_o       = (state_q == StHalt);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the stimulus pushes expected issues (pc, instr,
// link) and the redirect each issue returns; a monitor pops and compares on every
// accepted issue and also checks request/issue stability while stalled.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] link;
  } exp_t;

  typedef struct packed {
    logic        v;
    logic [1:0]  kind;
    logic [25:0] imm;
    logic [31:0] rg;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_kind = '0;
  logic [25:0] redirect_imm = '0;
  logic [31:0] redirect_reg = '0;
  logic        invpc;

  int n_cmp = 0;
  int n_fail = 0;

  exp_t sbq[$];
  rd_t  rq[$];

  int          ack_delay = 0;
  int          ready_delay = 0;
  logic        auto_ack = 1'b1;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;

  pc_fetch_unit dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .imem_addr_o      (imem_addr),
    .imem_req_o       (imem_req),
    .imem_ack_i       (imem_ack),
    .imem_rdata_i     (imem_rdata),
    .instr_o          (instr),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .pc_out_o         (pc_out),
    .link_addr_o      (link_addr),
    .redirect_valid_i (redirect_valid),
    .redirect_kind_i  (redirect_kind),
    .redirect_imm_i   (redirect_imm),
    .redirect_reg_i   (redirect_reg),
    .invpc_o          (invpc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic v, input logic [1:0] kind,
                      input logic [25:0] imm, input logic [31:0] rg);
    exp_t e;
    rd_t  r;
    e.pc = pc; e.instr = word(pc); e.link = pc + 32'd4;
    r.v = v; r.kind = kind; r.imm = imm; r.rg = rg;
    sbq.push_back(e);
    rq.push_back(r);
  endtask

  // Instruction memory model.
  int wcnt = 0;
  always @(negedge clk) begin
    if (!auto_ack) begin
      imem_ack   = man_ack;
      imem_rdata = man_rdata;
      wcnt       = 0;
    end else if (imem_req) begin
      if (wcnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = word(imem_addr);
        wcnt       = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_0000;
        wcnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      wcnt       = 0;
    end
  end

  // Downstream consumer: stalls ready_delay cycles per issue, returns the queued redirect
  // on accept and junk redirects otherwise.
  int rcnt = 0;
  always @(negedge clk) begin
    rd_t r;
    redirect_valid = 1'b1;
    redirect_kind  = 2'($urandom);
    redirect_imm   = 26'($urandom);
    redirect_reg   = $urandom;
    if (instr_valid) begin
      if (rcnt < ready_delay) begin
        instr_ready = 1'b0;
        rcnt++;
      end else begin
        instr_ready = 1'b1;
        rcnt = 0;
        if (rq.size() > 0) begin
          r = rq.pop_front();
          redirect_valid = r.v;
          redirect_kind  = r.kind;
          redirect_imm   = r.imm;
          redirect_reg   = r.rg;
        end else begin
          redirect_valid = 1'b0;
        end
      end
    end else begin
      instr_ready = 1'b0;
      rcnt = 0;
    end
  end

  // Monitor.
  logic        hold_r = 1'b0;
  logic        hold_v = 1'b0;
  logic [31:0] h_addr, h_instr, h_pc, h_link;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      hold_r = 1'b0;
      hold_v = 1'b0;
    end else begin
      if (hold_r) begin
        chk("req_held", 32'(imem_req), 32'd1);
        chk("addr_held", imem_addr, h_addr);
      end
      if (hold_v) begin
        chk("valid_held", 32'(instr_valid), 32'd1);
        chk("instr_held", instr, h_instr);
        chk("pc_out_held", pc_out, h_pc);
        chk("link_held", link_addr, h_link);
      end
      if (instr_valid && instr_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_issue_pc", pc_out, 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("issue_pc", pc_out, e.pc);
          chk("issue_instr", instr, e.instr);
          chk("issue_link", link_addr, e.link);
        end
      end
      hold_r = imem_req && !imem_ack;
      hold_v = instr_valid && !instr_ready;
      h_addr = imem_addr; h_instr = instr; h_pc = pc_out; h_link = link_addr;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_link"}, link_addr, 32'd0);
    chk({tag, "_invpc"}, 32'(invpc), 32'd0);
    chk({tag, "_pc"}, pc_out, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    sbq.delete();
    rq.delete();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("req_at_release", 32'(imem_req), 32'd0);
    @(negedge clk);
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
  endtask

  task automatic wait_halt(input logic [31:0] pc_exp);
    int k = 0;
    while (!invpc && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("halt_reached", 32'(invpc), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("halt_invpc", 32'(invpc), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_pc", pc_out, pc_exp);
    chk("issues_left", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Run 1: back-to-back, sequential then jal / jr / branches, ending in a bad jr.
    auto_ack = 1'b1; ack_delay = 0; ready_delay = 0;
    do_reset();
    push(32'h00, 1'b0, 2'b00, 26'h0, 32'h0);
    push(32'h04, 1'b0, 2'b00, 26'h0, 32'h0);
    push(32'h08, 1'b0, 2'b00, 26'h0, 32'h0);
    push(32'h0C, 1'b0, 2'b00, 26'h0, 32'h0);
    push(32'h10, 1'b1, 2'b01, 26'h6, 32'h0);        // jal -> 0x18
    push(32'h18, 1'b0, 2'b00, 26'h0, 32'h0);
    push(32'h1C, 1'b0, 2'b00, 26'h0, 32'h0);
    push(32'h20, 1'b1, 2'b10, 26'h0, 32'h14);       // jr -> 0x14
    push(32'h14, 1'b1, 2'b00, 26'h0_000A, 32'h0);   // branch 0x18+0x28 -> 0x40
    push(32'h40, 1'b1, 2'b00, 26'h0_FFFC, 32'h0);   // branch 0x44-0x10 -> 0x34
    push(32'h34, 1'b1, 2'b10, 26'h0, 32'h20);       // jr -> 0x20
    push(32'h20, 1'b1, 2'b10, 26'h0, 32'h1E);       // misaligned jr -> halt
    release_rst();
    wait_halt(32'h20);

    // Run 2: slow memory and stalling consumer; branch from 0 wraps negative.
    ack_delay = 3; ready_delay = 2;
    do_reset();
    push(32'h00, 1'b0, 2'b00, 26'h0, 32'h0);
    push(32'h04, 1'b0, 2'b00, 26'h0, 32'h0);
    push(32'h08, 1'b1, 2'b01, 26'h0, 32'h0);        // j -> 0x0
    push(32'h00, 1'b1, 2'b00, 26'h0_FFFE, 32'h0);   // -> 0xFFFFFFFC, illegal
    release_rst();
    wait_halt(32'h00);

    // Run 3: jump to last word, then sequential step off the top.
    ack_delay = 1; ready_delay = 1;
    do_reset();
    push(32'h000, 1'b1, 2'b10, 26'h0, 32'hFFC);
    push(32'hFFC, 1'b0, 2'b00, 26'h0, 32'h0);       // 0x1000 is out of range
    release_rst();
    wait_halt(32'hFFC);

    // Run 4: reset during a fetch wait with a late ack; reserved kind halts.
    auto_ack = 1'b0; man_ack = 1'b0; ack_delay = 0; ready_delay = 0;
    do_reset();
    push(32'h00, 1'b1, 2'b11, 26'h0, 32'h0);
    release_rst();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midfetch_reset");
    @(posedge clk);
    #1;
    man_ack = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    auto_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'd0);
    wait_halt(32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
